rv_wb_arbiter: RTL and testbench

Register-file write-port arbiter for the RISC-V core. It shares the single write port between the in-order pipeline writeback stage and a long-latency unit (multiplier/divider or slow-load return) that completes out of band. Long-unit results are queued in a small FIFO. The pipeline normally has priority; an age counter forces a long-unit grant and stalls the pipeline for one cycle to prevent starvation. Outputs drive the register file directly.

---
 rtl/rv_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_rv_wb_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_wb_arbiter.sv
// rv_wb_arbiter: shares the register-file write port between the pipeline
// writeback stage and a queued long-latency unit, with an age-based forced
// grant so queued results cannot starve behind a busy pipeline.
module rv_wb_arbiter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_pipe_reg_write,
    input  logic [4:0]  i_pipe_rd,
    input  logic [31:0] i_pipe_data,
    output logic        o_pipe_stall,

    input  logic        i_lu_valid,
    input  logic [4:0]  i_lu_rd,
    input  logic [31:0] i_lu_data,
    output logic        o_lu_ready,

    output logic [31:0] o_rd_busy,

    output logic [31:0] o_data,
    output logic [4:0]  o_rd,
    output logic        o_reg_write
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned DW  = 32;
    localparam int unsigned RW  = 5;
    localparam int unsigned AGW = 8;

    // FIFO storage and pointers
    logic [DW-1:0]  mem_data_q [DEPTH];
    logic [RW-1:0]  mem_rd_q   [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AGW-1:0] age_q, age_d;

    // Output register
    logic [DW-1:0]  data_q, data_d;
    logic [RW-1:0]  rd_q, rd_d;
    logic           reg_write_q, reg_write_d;

    // Decode and arbitration terms
    logic           pipe_req;
    logic           fifo_empty;
    logic           fifo_full;
    logic           force_grant;
    logic           grant_pipe;
    logic           pop;
    logic           push;
    logic [AW-1:0]  head_idx;
    logic [AW-1:0]  tail_idx;

    // Occupancy tracking for the busy scoreboard
    logic [PW-1:0]  count;
    logic [AW-1:0]  scan_idx;
    logic [DW-1:0]  rd_busy;

    // Arbitration: pipeline wins unless the FIFO head has aged out
    always_comb begin
        pipe_req    = i_pipe_reg_write & (i_pipe_rd != RW'(0));
        fifo_empty  = (wr_ptr_q == rd_ptr_q);
        fifo_full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        force_grant = !fifo_empty && (age_q == AGW'(MAX_WAIT));
        pop         = !fifo_empty && (force_grant || !pipe_req);
        grant_pipe  = pipe_req && !force_grant;
        push        = i_lu_valid && !fifo_full && (i_lu_rd != RW'(0));
        head_idx    = rd_ptr_q[AW-1:0];
        tail_idx    = wr_ptr_q[AW-1:0];
    end

    // Next-state for pointers, age counter and the write-port register
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        age_d       = age_q;
        data_d      = data_q;
        rd_d        = rd_q;
        reg_write_d = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Age clears on every pop and while empty; saturates at the limit
        if (fifo_empty || pop) begin
            age_d = AGW'(0);
        end else if (age_q != AGW'(MAX_WAIT)) begin
            age_d = age_q + AGW'(1);
        end

        if (pop) begin
            data_d      = mem_data_q[head_idx];
            rd_d        = mem_rd_q[head_idx];
            reg_write_d = 1'b1;
        end else if (grant_pipe) begin
            data_d      = i_pipe_data;
            rd_d        = i_pipe_rd;
            reg_write_d = 1'b1;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q    <= PW'(0);
            rd_ptr_q    <= PW'(0);
            age_q       <= AGW'(0);
            data_q      <= DW'(0);
            rd_q        <= RW'(0);
            reg_write_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            age_q       <= age_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
        end
    end

    // FIFO payload storage; contents are meaningless outside the pointer window
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_data_q[tail_idx] <= i_lu_data;
            mem_rd_q[tail_idx]   <= i_lu_rd;
        end
    end

    // Busy scoreboard: OR of one-hot destinations over every live entry
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        rd_busy  = DW'(0);
        scan_idx = head_idx;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            scan_idx = head_idx + AW'(k);
            if (PW'(k) < count) begin
                rd_busy = rd_busy | (DW'(1) << mem_rd_q[scan_idx]);
            end
        end
        rd_busy[0] = 1'b0;
    end

    assign o_pipe_stall = pipe_req & force_grant;
    assign o_lu_ready   = !fifo_full;
    assign o_rd_busy    = rd_busy;
    assign o_data       = data_q;
    assign o_rd         = rd_q;
    assign o_reg_write  = reg_write_q;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Bench for rv_wb_arbiter: a queue-based reference model predicts every
// register-file write and per-cycle stall/ready/busy, plus directed checks.
module tb_rv_wb_arbiter;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_WAIT = 8;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_rd = 5'd0;
    logic [31:0] pipe_data = 32'd0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rd = 5'd0;
    logic [31:0] lu_data = 32'd0;
    logic        o_pipe_stall;
    logic        o_lu_ready;
    logic [31:0] o_rd_busy;
    logic [31:0] o_data;
    logic [4:0]  o_rd;
    logic        o_reg_write;

    // Reference model state and scoreboard
    wr_t exp_q[$];
    wr_t mq[$];
    int  m_age = 0;
    bit  m_stalled = 1'b0;
    bit  m_accepted = 1'b0;
    bit  m_preq, m_empty, m_full, m_force, m_pop;
    int  lu_left = 0;
    int  stall_cnt = 0;
    int  errors = 0;
    int  checks = 0;

    rv_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_pipe_reg_write (pipe_we),
        .i_pipe_rd        (pipe_rd),
        .i_pipe_data      (pipe_data),
        .o_pipe_stall     (o_pipe_stall),
        .i_lu_valid       (lu_valid),
        .i_lu_rd          (lu_rd),
        .i_lu_data        (lu_data),
        .o_lu_ready       (o_lu_ready),
        .o_rd_busy        (o_rd_busy),
        .o_data           (o_data),
        .o_rd             (o_rd),
        .o_reg_write      (o_reg_write)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: decide the grant from the inputs sampled at this edge
    always @(posedge clk) begin
        if (rst_n) begin
            m_preq     = pipe_we && (pipe_rd != 5'd0);
            m_empty    = (mq.size() == 0);
            m_full     = (mq.size() == DEPTH);
            m_force    = !m_empty && (m_age == MAX_WAIT);
            m_pop      = !m_empty && (m_force || !m_preq);
            m_stalled  = m_preq && m_force;
            m_accepted = lu_valid && !m_full;
            if (m_pop)
                exp_q.push_back(mq.pop_front());
            else if (m_preq)
                exp_q.push_back(wr_t'({pipe_rd, pipe_data}));
            if (m_empty || m_pop)
                m_age = 0;
            else if (m_age < MAX_WAIT)
                m_age++;
            if (m_accepted && lu_rd != 5'd0)
                mq.push_back(wr_t'({lu_rd, lu_data}));
        end
    end

    // Mid-cycle comparison of registered write and combinational status
    always @(negedge clk) begin
        wr_t         e;
        logic [31:0] mb;
        bit          n_preq, n_force;
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_en", 32'(o_reg_write), 32'd1);
                check("wr_rd", 32'(o_rd), 32'(e.rd));
                check("wr_data", o_data, e.data);
            end else begin
                check("wr_idle", 32'(o_reg_write), 32'd0);
            end
            n_preq  = pipe_we && (pipe_rd != 5'd0);
            n_force = (mq.size() != 0) && (m_age == MAX_WAIT);
            check("stall", 32'(o_pipe_stall), 32'(n_preq && n_force));
            check("lu_ready", 32'(o_lu_ready), 32'(mq.size() < DEPTH));
            mb = 32'd0;
            foreach (mq[i]) mb = mb | (32'd1 << mq[i].rd);
            check("rd_busy", o_rd_busy, mb);
            if (o_pipe_stall) stall_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One cycle of protocol-respecting stimulus; stalled/refused inputs are held
    task automatic run_cycle(input bit pipe_on, input int lu_pct, input bit zero_ok);
        if (!(pipe_we && m_stalled)) begin
            if (pipe_on) begin
                pipe_we   = 1'b1;
                pipe_rd   = zero_ok ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 31));
                pipe_data = $urandom;
            end else begin
                pipe_we = 1'b0;
            end
        end
        if (!(lu_valid && !m_accepted)) begin
            if (lu_left > 0 && int'($urandom_range(0, 99)) < lu_pct) begin
                lu_valid = 1'b1;
                lu_rd    = zero_ok ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 31));
                lu_data  = $urandom;
                lu_left--;
            end else begin
                lu_valid = 1'b0;
            end
        end
        cyc();
    endtask

    task automatic clear_model();
        mq.delete();
        exp_q.delete();
        m_age      = 0;
        m_stalled  = 1'b0;
        m_accepted = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_we", 32'(o_reg_write), 32'd0);
        check("rst_rd", 32'(o_rd), 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_ready", 32'(o_lu_ready), 32'd1);
        check("rst_stall", 32'(o_pipe_stall), 32'd0);
        check("rst_busy", o_rd_busy, 32'd0);
        #1 rst_n = 1'b1;
        cyc();

        // Pipeline write with idle FIFO
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1234_5678;
        #1 check("t1_stall", 32'(o_pipe_stall), 32'd0);
        cyc();
        pipe_we = 1'b0;
        check("t1_we", 32'(o_reg_write), 32'd1);
        check("t1_rd", 32'(o_rd), 32'd5);
        check("t1_data", o_data, 32'h1234_5678);
        cyc();

        // Long-unit write with idle pipeline: busy for one cycle, 2-cycle latency
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'hDEAD_BEEF;
        cyc();
        lu_valid = 1'b0;
        check("t2_busy7", 32'(o_rd_busy[7]), 32'd1);
        check("t2_nowr", 32'(o_reg_write), 32'd0);
        cyc();
        check("t2_we", 32'(o_reg_write), 32'd1);
        check("t2_rd", 32'(o_rd), 32'd7);
        check("t2_data", o_data, 32'hDEAD_BEEF);
        check("t2_busy0", o_rd_busy, 32'd0);
        cyc();

        // Continuous pipeline, 5 back-to-back long-unit results, forced grant timing
        stall_cnt = 0;
        lu_left   = 5;
        repeat (4) run_cycle(1'b1, 100, 1'b0);
        check("t3_full", 32'(o_lu_ready), 32'd0);
        repeat (5) run_cycle(1'b1, 100, 1'b0);
        check("t3_nostall", 32'(stall_cnt), 32'd0);
        run_cycle(1'b1, 100, 1'b0);
        check("t3_force", 32'(stall_cnt), 32'd1);
        run_cycle(1'b1, 100, 1'b0);
        check("t3_once", 32'(stall_cnt), 32'd1);
        repeat (30) run_cycle(1'b1, 100, 1'b0);
        repeat (10) run_cycle(1'b0, 0, 1'b0);

        // rd = x0 on both sides: no write, no stall, nothing queued
        pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hAAAA_5555;
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h5555_AAAA;
        #1 check("t4_stall", 32'(o_pipe_stall), 32'd0);
        cyc();
        pipe_we = 1'b0; lu_valid = 1'b0;
        check("t4_we", 32'(o_reg_write), 32'd0);
        check("t4_busy", o_rd_busy, 32'd0);
        check("t4_ready", 32'(o_lu_ready), 32'd1);
        cyc();

        // Full FIFO: simultaneous pop and valid refuses the push, accepts next cycle
        lu_left = 4;
        repeat (4) run_cycle(1'b1, 100, 1'b0);
        pipe_we = 1'b0;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'hC0FF_EE00;
        #1 check("t5_refuse", 32'(o_lu_ready), 32'd0);
        cyc();
        check("t5_ready", 32'(o_lu_ready), 32'd1);
        cyc();
        lu_valid = 1'b0;
        repeat (3) begin
            lu_left = 6;
            repeat (6) run_cycle(1'b1, 100, 1'b0);
            repeat (8) run_cycle(1'b0, 0, 1'b0);
        end

        // Asynchronous reset mid-cycle with entries queued and a write in flight
        lu_left = 3;
        repeat (3) run_cycle(1'b1, 100, 1'b0);
        check("t6_pre_we", 32'(o_reg_write), 32'd1);
        #2;
        rst_n = 1'b0;
        pipe_we = 1'b0; lu_valid = 1'b0;
        clear_model();
        #1;
        check("t6_we", 32'(o_reg_write), 32'd0);
        check("t6_rd", 32'(o_rd), 32'd0);
        check("t6_data", o_data, 32'd0);
        check("t6_ready", 32'(o_lu_ready), 32'd1);
        check("t6_busy", o_rd_busy, 32'd0);
        check("t6_stall", 32'(o_pipe_stall), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) run_cycle(1'b0, 0, 1'b0);
        check("t6_post_busy", o_rd_busy, 32'd0);

        // Random mix, including x0 destinations on both sides
        lu_left = 1000;
        repeat (300) run_cycle(1'($urandom_range(0, 1)), 50, 1'b1);
        lu_left = 0;
        repeat (20) run_cycle(1'b0, 0, 1'b1);
        check("end_drained", 32'(mq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
